// File: rtl/alu_flags_pipe_if.sv
// Request/result bundle between the register-file read side and the ALU,
// and between the ALU and writeback/branch logic.
interface alu_flags_pipe_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [2:0]       op;
  logic             flag_we;
  logic             flag_clr;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] S;
  logic             out_valid;
  logic             ZF;
  logic             CF;
  logic             NF;
  logic             VF;

  // Controller side: issues operations, consumes result and flags.
  modport master (
    output in_valid, op, flag_we, flag_clr, A, B,
    input  S, out_valid, ZF, CF, NF, VF
  );

  // ALU side.
  modport slave (
    input  in_valid, op, flag_we, flag_clr, A, B,
    output S, out_valid, ZF, CF, NF, VF
  );
endinterface

// File: rtl/alu_flags_pipe.sv
// Width-generic 8-op ALU with a registered result and a persistent
// ZF/CF/NF/VF status register. ADC/SBC take the carry from the stored CF,
// so multi-word arithmetic chains one word per cycle without bubbles.
module alu_flags_pipe #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  alu_flags_pipe_if.slave    bus
);

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_ADC   = 3'b001,
    OP_SUB   = 3'b010,
    OP_SBC   = 3'b011,
    OP_AND   = 3'b100,
    OP_OR    = 3'b101,
    OP_XOR   = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  typedef struct packed {
    logic zf;
    logic cf;
    logic nf;
    logic vf;
  } flags_t;

  op_e              op;
  logic [WIDTH-1:0] bx;
  logic             cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] result;
  flags_t           flags_q;
  flags_t           flags_d;
  logic [WIDTH-1:0] s_q;
  logic             out_valid_q;

  assign op = op_e'(bus.op);

  // Operand conditioning, shared adder, result mux and next-flag values.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    bx      = bus.B;
    cin     = 1'b0;
    result  = '0;
    flags_d = flags_q;

    // Subtract ops invert B; carry-chained ops feed in the stored CF.
    if (op == OP_SUB || op == OP_SBC) bx = ~bus.B;
    case (op)
      OP_SUB:          cin = 1'b1;
      OP_ADC, OP_SBC:  cin = flags_q.cf;
      default:         cin = 1'b0;
    endcase
    sum = {1'b0, bus.A} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};

    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBC: result = sum[WIDTH-1:0];
      OP_AND:                         result = bus.A & bus.B;
      OP_OR:                          result = bus.A | bus.B;
      OP_XOR:                         result = bus.A ^ bus.B;
      default:                        result = bus.B;
    endcase

    flags_d.zf = (result == '0);
    flags_d.nf = result[WIDTH-1];
    if (!op[2]) begin
      flags_d.cf = sum[WIDTH];
      flags_d.vf = (bus.A[WIDTH-1] == bx[WIDTH-1]) &&
                   (result[WIDTH-1] != bus.A[WIDTH-1]);
    end else begin
      // Logic ops and PASSB leave CF alone so a carry survives them.
      flags_d.cf = flags_q.cf;
      flags_d.vf = 1'b0;
    end
  end

  // Result register, valid pulse and flag register; reset wins over all.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples the pre-edge values, e.g. ADC sees the old CF.
    if (!rst_n) begin
      s_q         <= '0;
      out_valid_q <= 1'b0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) s_q <= result;
      if (bus.flag_clr)
        flags_q <= '0;
      else if (bus.in_valid && bus.flag_we)
        flags_q <= flags_d;
    end
  end

  assign bus.S         = s_q;
  assign bus.out_valid = out_valid_q;
  assign bus.ZF        = flags_q.zf;
  assign bus.CF        = flags_q.cf;
  assign bus.NF        = flags_q.nf;
  assign bus.VF        = flags_q.vf;

endmodule

// File: tb/tb_alu_flags_pipe.sv
// Directed vector table on a 4-bit instance, hand-written reset/idle/clear
// sequences, and an 8-cycle back-to-back run on 4- and 16-bit instances
// checked against an arithmetic reference model.
module tb_alu_flags_pipe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_flags_pipe_if #(.WIDTH(4))  bus4 ();
  alu_flags_pipe_if #(.WIDTH(16)) bus16 ();

  alu_flags_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
  alu_flags_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // flags packed as {ZF,CF,NF,VF}
  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       we;
    logic       clr;
    logic [3:0] s;
    logic [3:0] flg;
  } vec_t;

  typedef struct {
    logic [31:0] s;
    logic [3:0]  flg;
  } res_t;

  // Reference model: plain integer arithmetic with signed-range overflow.
  function automatic res_t ref_op(input int w, input logic [2:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fin);
    res_t   r;
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua = longint'(a) & mask;
    longint ub = longint'(b) & mask;
    longint sa = (ua >= half) ? ua - 2 * half : ua;
    longint sb = (ub >= half) ? ub - 2 * half : ub;
    longint cin = fin[2] ? 1 : 0;
    longint bor = fin[2] ? 0 : 1;
    longint full = 0;
    longint sfull = 0;
    logic   c = fin[2];
    logic   v = 1'b0;
    logic   arith = 1'b1;
    case (op)
      3'd0: begin full = ua + ub;        sfull = sa + sb;        c = (full > mask); end
      3'd1: begin full = ua + ub + cin;  sfull = sa + sb + cin;  c = (full > mask); end
      3'd2: begin full = ua - ub;        sfull = sa - sb;        c = (ua >= ub); end
      3'd3: begin full = ua - ub - bor;  sfull = sa - sb - bor;  c = (ua >= ub + bor); end
      3'd4: begin full = ua & ub; arith = 1'b0; end
      3'd5: begin full = ua | ub; arith = 1'b0; end
      3'd6: begin full = ua ^ ub; arith = 1'b0; end
      default: begin full = ub; arith = 1'b0; end
    endcase
    full = full & mask;
    if (arith) v = (sfull > half - 1) || (sfull < -half);
    r.s   = 32'(full);
    r.flg = {(full == 0), c, ((full >> (w - 1)) & 1) == 1, v};
    return r;
  endfunction

  task automatic drive4(input logic v, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic we, input logic clr);
    bus4.in_valid = v;  bus4.op = op;  bus4.A = a;  bus4.B = b;
    bus4.flag_we = we;  bus4.flag_clr = clr;
  endtask

  task automatic check4(input string tag, input logic [3:0] s, input logic ov,
                        input logic [3:0] flg);
    check({tag, " S"}, 32'(bus4.S), 32'(s));
    check({tag, " out_valid"}, 32'(bus4.out_valid), 32'(ov));
    check({tag, " flags"}, 32'({bus4.ZF, bus4.CF, bus4.NF, bus4.VF}), 32'(flg));
  endtask

  vec_t vecs[19];

  initial begin
    //          op      A     B    we clr  S     ZCNV
    vecs[0]  = '{3'd0, 4'h7, 4'h1, 1, 0, 4'h8, 4'b0011};
    vecs[1]  = '{3'd0, 4'hF, 4'h1, 1, 0, 4'h0, 4'b1100};
    vecs[2]  = '{3'd1, 4'h0, 4'h0, 1, 0, 4'h1, 4'b0000};
    vecs[3]  = '{3'd1, 4'hF, 4'h0, 1, 0, 4'hF, 4'b0010};
    vecs[4]  = '{3'd2, 4'h3, 4'h5, 1, 0, 4'hE, 4'b0010};
    vecs[5]  = '{3'd2, 4'h5, 4'h5, 1, 0, 4'h0, 4'b1100};
    vecs[6]  = '{3'd0, 4'h0, 4'h0, 1, 0, 4'h0, 4'b1000};
    vecs[7]  = '{3'd3, 4'h5, 4'h5, 1, 0, 4'hF, 4'b0010};
    vecs[8]  = '{3'd0, 4'hF, 4'h2, 1, 0, 4'h1, 4'b0100};
    vecs[9]  = '{3'd4, 4'hF, 4'h0, 1, 0, 4'h0, 4'b1100};
    vecs[10] = '{3'd0, 4'h1, 4'h1, 0, 0, 4'h2, 4'b1100};
    vecs[11] = '{3'd2, 4'h0, 4'h1, 1, 1, 4'hF, 4'b0000};
    vecs[12] = '{3'd5, 4'h5, 4'hA, 1, 0, 4'hF, 4'b0010};
    vecs[13] = '{3'd6, 4'hF, 4'hF, 1, 0, 4'h0, 4'b1000};
    vecs[14] = '{3'd2, 4'h8, 4'h1, 1, 0, 4'h7, 4'b0101};
    vecs[15] = '{3'd3, 4'h8, 4'h1, 1, 0, 4'h7, 4'b0101};
    vecs[16] = '{3'd7, 4'h0, 4'h9, 1, 0, 4'h9, 4'b0110};
    vecs[17] = '{3'd0, 4'h8, 4'h8, 1, 0, 4'h0, 4'b1101};
    vecs[18] = '{3'd1, 4'h7, 4'h0, 1, 0, 4'h8, 4'b0011};

    bus16.in_valid = 1'b0; bus16.op = 3'd0; bus16.A = '0; bus16.B = '0;
    bus16.flag_we = 1'b0;  bus16.flag_clr = 1'b0;

    // Reset overrides a simultaneous valid ADD.
    rst_n = 1'b0;
    drive4(1'b1, 3'd0, 4'h3, 4'h4, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 check4("reset", 4'h0, 1'b0, 4'b0000);

    // Release reset while idle: everything holds.
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b0, 3'd0, 4'h3, 4'h4, 1'b1, 1'b0);
    @(posedge clk);
    #1 check4("post-reset idle", 4'h0, 1'b0, 4'b0000);

    // Directed table, one op per cycle back to back.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive4(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].we, vecs[i].clr);
      @(posedge clk);
      #1 check4($sformatf("vec%0d", i), vecs[i].s, 1'b1, vecs[i].flg);
    end

    // out_valid is a single-cycle pulse; S and flags hold while idle.
    @(negedge clk);
    drive4(1'b0, 3'd0, 4'hF, 4'hF, 1'b1, 1'b0);
    @(posedge clk);
    #1 check4("idle hold", 4'h8, 1'b0, 4'b0011);

    // flag_clr without an op clears flags only.
    @(negedge clk);
    drive4(1'b0, 3'd0, 4'h1, 4'h1, 1'b0, 1'b1);
    @(posedge clk);
    #1 check4("clr idle", 4'h8, 1'b0, 4'b0000);

    // Reset in the middle of a carry chain clears CF.
    @(negedge clk);
    drive4(1'b1, 3'd0, 4'hF, 4'h1, 1'b1, 1'b0);
    @(posedge clk);
    #1 check4("chain start", 4'h0, 1'b1, 4'b1100);
    @(negedge clk);
    rst_n = 1'b0;
    drive4(1'b1, 3'd1, 4'hF, 4'hF, 1'b1, 1'b0);
    @(posedge clk);
    #1 check4("mid-chain reset", 4'h0, 1'b0, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b1, 3'd1, 4'h0, 4'h0, 1'b1, 1'b0);
    @(posedge clk);
    #1 check4("adc after reset", 4'h0, 1'b1, 4'b1000);

    // Throughput: 8 back-to-back ops on both widths against the model.
    begin
      logic [3:0] f4  = 4'b1000;
      logic [3:0] f16 = 4'b0000;
      int ov4 = 0;
      int ov16 = 0;
      for (int i = 0; i < 8; i++) begin
        logic [3:0]  a4  = 4'($urandom);
        logic [3:0]  b4  = 4'($urandom);
        logic [15:0] a16 = 16'($urandom);
        logic [15:0] b16 = 16'($urandom);
        res_t r4, r16;
        @(negedge clk);
        drive4(1'b1, 3'(i), a4, b4, 1'b1, 1'b0);
        bus16.in_valid = 1'b1; bus16.op = 3'(i); bus16.A = a16; bus16.B = b16;
        bus16.flag_we = 1'b1;  bus16.flag_clr = 1'b0;
        r4  = ref_op(4,  3'(i), 32'(a4),  32'(b4),  f4);
        r16 = ref_op(16, 3'(i), 32'(a16), 32'(b16), f16);
        f4  = r4.flg;
        f16 = r16.flg;
        @(posedge clk);
        #1;
        if (bus4.out_valid)  ov4++;
        if (bus16.out_valid) ov16++;
        check($sformatf("tp4 op%0d S", i), 32'(bus4.S), r4.s);
        check($sformatf("tp4 op%0d flags", i),
              32'({bus4.ZF, bus4.CF, bus4.NF, bus4.VF}), 32'(r4.flg));
        check($sformatf("tp16 op%0d S", i), 32'(bus16.S), r16.s);
        check($sformatf("tp16 op%0d flags", i),
              32'({bus16.ZF, bus16.CF, bus16.NF, bus16.VF}), 32'(r16.flg));
      end
      @(negedge clk);
      bus4.in_valid = 1'b0;
      bus16.in_valid = 1'b0;
      @(posedge clk);
      #1;
      check("tp4 out_valid count", 32'(ov4), 32'd8);
      check("tp16 out_valid count", 32'(ov16), 32'd8);
      check("tp4 out_valid drop", 32'(bus4.out_valid), 32'd0);
      check("tp16 out_valid drop", 32'(bus16.out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
